fifo_write_arbiter: RTL
=======================

Name: fifo_write_arbiter

Overview:
- Shares the single 8-bit write port of the byte-to-word packing FIFO between two byte producers, A and B.
- Arbitration granularity is one 16-bit word (two bytes), so a packed FIFO word never mixes bytes from different producers.
- Grants are round-robin, with a maximum burst length per grant.
- Keeps a per-requester count of words forwarded, for debug and status.

Parameters:
- BURST_WORDS, 4: maximum words forwarded per grant before re-arbitration. Legal range 1..255.
- CNT_W, 16: width of the per-requester word counters.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- a_data  input  8  requester A byte
- a_valid  input  1  requester A has a byte
- a_ready  output  1  A byte accepted this cycle when a_valid && a_ready
- b_data  input  8  requester B byte
- b_valid  input  1  requester B has a byte
- b_ready  output  1  B byte accepted this cycle when b_valid && b_ready
- fifo_data  output  8  byte to FIFO data_in
- fifo_valid  output  1  to FIFO input_valid
- fifo_enable  input  1  from FIFO input_enable (not full)
- grant  output  2  one-hot current owner: bit0 = A, bit1 = B; 2'b00 when idle
- words_a  output  CNT_W  words forwarded from A, wraps modulo 2^CNT_W
- words_b  output  CNT_W  words forwarded from B, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst high at a clk edge):
  - state = IDLE, grant = 00, byte_cnt = 0, burst_cnt = 0, words_a = words_b = 0.
  - last_grant = B, so A wins the first tie.
- States: IDLE, OWN_A, OWN_B.
- IDLE:
  - fifo_valid = 0, a_ready = b_ready = 0, fifo_data = 0.
  - If exactly one valid is high, that requester is granted at the next edge.
  - If both are high, the requester that is not last_grant is granted.
  - Arbitration latency: 1 cycle from valid to grant.
- OWN_x, combinational pass-through:
  - fifo_data = x_data, fifo_valid = x_valid, x_ready = fifo_enable.
  - The other requester's ready = 0.
- Transfer: a byte moves when fifo_valid && fifo_enable.
  - byte_cnt toggles on each transfer.
  - On the transfer with byte_cnt = 1 (second byte of a word): burst_cnt increments and words_x increments.
- Release only at a word boundary (byte_cnt = 0 after the edge), when either condition holds:
  - burst_cnt reaches BURST_WORDS, or
  - x_valid is low at a boundary with no transfer that cycle (idle release).
- Never release mid-word:
  - If x_valid drops after the first byte, hold the grant indefinitely until the second byte arrives.
  - If fifo_enable drops mid-word, hold the grant likewise.
- On release, the next state is chosen at the same edge, with no idle bubble:
  - other requester valid: go to OWN_other;
  - else own valid still high (burst exhausted): start a new burst in OWN_x;
  - else go to IDLE.
  - On entering any OWN state, burst_cnt = 0 and last_grant is updated.
- Idle-release timing: an idle-release decision uses the valids sampled in that cycle.
- fifo_enable low: no transfer; counters hold; the state machine holds (no release based on FIFO backpressure).
- Counters wrap silently: 0xFFFF + 1 = 0x0000.
- Reset mid-word: the partial word is discarded by this block. The FIFO must be reset in the same cycle by the system; this block does not complete the word.
- grant is registered and equals the state encoding. All other outputs are combinational from the state and inputs.

Test Plan:
- Reset, then A sends 8 bytes 0x01..0x08 with B idle and fifo_enable = 1.
  - grant = 01 one cycle after a_valid.
  - Bytes appear on fifo_data in order.
  - After 8 bytes, words_a = 4 and grant returns to 00.
- Both valid from reset, each streaming continuously, BURST_WORDS = 4.
  - A gets 8 bytes, then B gets 8 bytes, then A again, with no idle cycle between grants.
  - Per boundary: after the first A burst, words_a = 4, words_b = 0; after the first B burst, words_a = words_b = 4.
- A sends byte 0x11, then drops a_valid for 5 cycles while b_valid is high, then sends 0x22.
  - grant stays 01 throughout; b_ready = 0 for the whole gap.
  - 0x22 is forwarded; B is granted on the next edge; words_a = 1.
- fifo_enable = 0 for 3 cycles in the middle of an A word.
  - a_ready = 0, no counter change, grant held.
  - Transfer resumes when fifo_enable returns to 1.
- Preload words_a = 0xFFFF via 65535 A words, then one more A word.
  - words_a = 0x0000; words_b unchanged.
- rst asserted for one cycle after the first byte of a B word.
  - Next cycle: grant = 00, words_a = words_b = 0, fifo_valid = 0.
  - After release with both valid, A is granted first.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - word-granular round-robin arbiter for the packing FIFO write port
//
// Purpose:
//   Two byte producers (A, B) share the 8-bit write port of a byte-to-word
//   packing FIFO. Ownership changes only on 16-bit word boundaries so a packed
//   word never mixes producers. Grants rotate round-robin, and each grant is
//   limited to BURST_WORDS words before re-arbitration.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   a_data/a_valid/a_ready  producer A byte stream
//   b_data/b_valid/b_ready  producer B byte stream
//   fifo_data/fifo_valid    byte stream into the FIFO
//   fifo_enable             FIFO can accept a byte (not full)
//   grant                   registered one-hot owner (bit0 A, bit1 B, 00 idle)
//   words_a/words_b         wrapping count of words forwarded per producer

module fifo_write_arbiter #(
  parameter int BURST_WORDS = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [7:0]       b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [7:0]       fifo_data,
  output logic             fifo_valid,
  input  logic             fifo_enable,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] words_a,
  output logic [CNT_W-1:0] words_b
);

  // State encoding doubles as the one-hot grant value.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_OWN_A = 2'b01,
    ST_OWN_B = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             byte_cnt_q, byte_cnt_d;   // 1 = first byte of a word already sent
  logic [7:0]       burst_cnt_q, burst_cnt_d;
  logic             last_b_q, last_b_d;       // 1 = B held the most recent grant
  logic [CNT_W-1:0] words_a_q, words_a_d;
  logic [CNT_W-1:0] words_b_q, words_b_d;

  logic             own_valid;
  logic             other_valid;
  logic             xfer;
  logic             word_done;
  logic             release_now;
  logic [8:0]       burst_inc;

  always_comb begin
    fifo_data   = 8'h00;
    fifo_valid  = 1'b0;
    a_ready     = 1'b0;
    b_ready     = 1'b0;
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    burst_cnt_d = burst_cnt_q;
    last_b_d    = last_b_q;
    words_a_d   = words_a_q;
    words_b_d   = words_b_q;
    own_valid   = 1'b0;
    other_valid = 1'b0;

    case (state_q)
      ST_OWN_A: begin
        fifo_data   = a_data;
        fifo_valid  = a_valid;
        a_ready     = fifo_enable;
        own_valid   = a_valid;
        other_valid = b_valid;
      end
      ST_OWN_B: begin
        fifo_data   = b_data;
        fifo_valid  = b_valid;
        b_ready     = fifo_enable;
        own_valid   = b_valid;
        other_valid = a_valid;
      end
      default: ;
    endcase

    xfer      = fifo_valid && fifo_enable;
    word_done = xfer && byte_cnt_q;
    burst_inc = {1'b0, burst_cnt_q} + 9'd1;

    if (xfer) begin
      byte_cnt_d = ~byte_cnt_q;
    end
    if (word_done) begin
      burst_cnt_d = burst_inc[7:0];
      if (state_q == ST_OWN_A) begin
        words_a_d = words_a_q + CNT_ONE;
      end else begin
        words_b_d = words_b_q + CNT_ONE;
      end
    end

    // Release only lands on a word boundary: either the burst just finished
    // with the second byte of a word, or the owner is idle with no half word
    // outstanding. FIFO backpressure alone never releases.
    release_now = (state_q != ST_IDLE) &&
                  ((word_done && (burst_inc == 9'(BURST_WORDS))) ||
                   (!xfer && !byte_cnt_q && !own_valid));

    if (state_q == ST_IDLE) begin
      if (a_valid && (!b_valid || last_b_q)) begin
        state_d     = ST_OWN_A;
        burst_cnt_d = 8'd0;
        last_b_d    = 1'b0;
      end else if (b_valid) begin
        state_d     = ST_OWN_B;
        burst_cnt_d = 8'd0;
        last_b_d    = 1'b1;
      end
    end else if (release_now) begin
      // Hand over at the same edge; a still-valid owner with no competitor
      // simply starts a fresh burst.
      if (other_valid) begin
        state_d = (state_q == ST_OWN_A) ? ST_OWN_B : ST_OWN_A;
      end else if (own_valid) begin
        state_d = state_q;
      end else begin
        state_d = ST_IDLE;
      end
      if (state_d != ST_IDLE) begin
        burst_cnt_d = 8'd0;
        last_b_d    = (state_d == ST_OWN_B);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= 1'b0;
      burst_cnt_q <= 8'd0;
      last_b_q    <= 1'b1;
      words_a_q   <= '0;
      words_b_q   <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      last_b_q    <= last_b_d;
      words_a_q   <= words_a_d;
      words_b_q   <= words_b_d;
    end
  end

  assign grant   = state_q;
  assign words_a = words_a_q;
  assign words_b = words_b_q;

endmodule
